// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word fetch over req/gnt/rvalid into a prefetch FIFO
// drained by decode. Optional macro FETCH_PERF_CNT_EN adds stall/flush performance counters.

package fetch_unit_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   discard_q, discard_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  fetch_entry_t       head_q, head_d;
  logic               valid_q, valid_d;
  fetch_entry_t       mem_q [FIFO_DEPTH];

  logic               accept;
  logic               push;
  logic               pop;
  logic               credit_ok;
  logic [31:0]        redirect_aligned;
  fetch_entry_t       new_entry;
  logic               unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign new_entry           = '{instr: imem_rdata, pc: resp_pc_q};

  // Next-state: request issue, credit accounting, response steering and FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rptr_d        = rptr_q;
    wptr_d        = wptr_q;
    head_d        = head_q;
    valid_d       = valid_q;
    imem_req      = 1'b0;
    accept        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    credit_ok     = (SUM_W'(outstanding_q) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH);

    case (state_q)
      FETCH:   imem_req = !reset && !redirect_valid && credit_ok;
      DRAIN:   imem_req = 1'b0;
      default: imem_req = 1'b0;
    endcase

    accept = imem_req && imem_gnt;
    pop    = valid_q && out_ready;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);

    if (imem_rvalid) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CNT_W'(1);
      end else begin
        push = 1'b1;
      end
    end

    // Redirect: nothing is accepted this cycle, so every response still owed is stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      push       = 1'b0;
      discard_d  = outstanding_q - CNT_W'(imem_rvalid);
    end

    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    rptr_d  = rptr_q + PTR_W'(pop);
    wptr_d  = wptr_q + PTR_W'(push);
    if (redirect_valid) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end

    // Head register tracks the entry at rptr_d, bypassing the incoming word when it lands at the head.
    if (count_d != '0) begin
      if (push && ((count_q - CNT_W'(pop)) == '0)) begin
        head_d = new_entry;
      end else begin
        head_d = mem_q[rptr_d];
      end
    end
    valid_d = (count_d != '0);

    state_d = (discard_d != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      head_q        <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      head_q        <= head_d;
      valid_q       <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wptr_q] <= new_entry;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = valid_q;
  assign out_instr = head_q.instr;
  assign out_pc    = head_q.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counters: decode starved, and redirect strobes seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_ready && !valid_q && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (redirect_valid && (flush_q != '1)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rvalid && (outstanding_q == '0)))
        else $error("fetch_unit: rvalid with no outstanding request");
      assert (!(push && !pop && (count_q == DEPTH_CNT)))
        else $error("fetch_unit: push into full prefetch FIFO");
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle decode/execute datapath. It generates sequential word addresses, issues requests to instruction memory over a req/gnt/rvalid interface, and buffers returned words with their PCs in a prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. A redirect input (branch/jump target) flushes the FIFO and discards in-flight responses.

Parameters:
FIFO_DEPTH, 4, prefetch entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address, bits[1:0]=00
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid, in order, >=1 cycle after grant
imem_rdata  input  32  response instruction word
redirect_valid  input  1  PC redirect strobe
redirect_pc  input  32  redirect target; bits[1:0] ignored (forced 00)
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts
out_instr  output  32  instruction at FIFO head
out_pc  output  32  PC of out_instr

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. Reset has priority over all inputs.
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0. Internal reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=FETCH.
- Instruction memory is reset together with this block. Responses issued before reset are not delivered.
- States: FETCH (issue requests) and DRAIN (drop stale responses, no requests).
- imem_req=1 only when state==FETCH, !redirect_valid and outstanding+fifo_count < FIFO_DEPTH (credit rule). Result: the FIFO can never overflow.
- imem_addr=fetch_pc. While imem_req=1 and imem_gnt=0, addr is held stable unless a redirect occurs. A redirect withdraws the pending request; memory permits this.
- Accept (imem_req & imem_gnt): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
- Each imem_rvalid: outstanding -= 1.
  - If discard>0: data dropped, discard -= 1.
  - Else: push {imem_rdata, resp_pc} and resp_pc += 4.
- Minimum latency: grant in cycle N, rvalid in N+1, out_valid=1 in N+2.
- out_valid = FIFO non-empty. out_instr/out_pc come from head registers. Pop on out_valid & out_ready.
- Push and pop in the same cycle are allowed at any occupancy, including full (count unchanged).
- rvalid with no outstanding request, or push to a full FIFO, is a protocol error and must trigger a simulation assertion.
- Redirect cycle (redirect_valid=1):
  - fetch_pc and resp_pc load {redirect_pc[31:2],2'b00}.
  - FIFO cleared next cycle. A pop in the redirect cycle is honoured; out_valid=0 the following cycle.
  - discard_next = outstanding - rvalid_this_cycle, since no request is accepted in the redirect cycle.
  - state_next = DRAIN if discard_next>0, else FETCH.
- DRAIN: leaves to FETCH in the cycle after discard reaches 0. A redirect in DRAIN updates the PCs and recomputes discard with the same formula.
- Counters: outstanding and discard are clog2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs stall_cycles[31:0] and flush_count[15:0], both reset to 0, saturating.
  - stall_cycles increments each cycle with out_ready=1 and out_valid=0.
  - flush_count increments on each redirect_valid cycle.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then gnt=1 always, rvalid 1 cycle after grant, out_ready=1 → out_pc sequence 0,4,8,... with first out_valid two cycles after the first grant; one instruction per cycle sustained.
- out_ready=0, FIFO_DEPTH=4 → exactly 4 grants, imem_req stays 0, out_pc=0 held; raise out_ready → drains 0,4,8,12, fetching resumes at 16.
- gnt held 0 for 3 cycles → imem_req=1 and imem_addr=0 stable throughout; accepted on the 4th cycle.
- 2 requests outstanding, redirect_pc=0x103 → next two rvalid data dropped, state DRAIN; then first request addr=0x100 and out_pc=0x100.
- Redirect coinciding with out_valid & out_ready → head popped, then out_valid=0; redirect coinciding with an rvalid → that response also dropped and discard counts correctly.
- Reset asserted mid-drain with FIFO holding 3 entries → next cycle out_valid=0, imem_addr=RESET_PC, state FETCH.
